cla_pipe_adder: RTL
===================

Name: cla_pipe_adder

Overview:
- Parametrised, pipelined carry-lookahead adder/subtractor; successor to the 4-bit combinational lookahead carry block.
- Operand is split into GRP-bit lookahead groups. Each pipeline stage resolves one group with full intra-group carry lookahead and registers the partial sum and the inter-group carry.
- Valid/ready streaming handshake on both sides.
- Sits between operand-issue logic and the result writeback of the datapath.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a multiple of GRP, minimum GRP.
- GRP, 4, bits per lookahead group; pipeline depth N = WIDTH/GRP stages.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand beat valid
- in_ready  output  1  block accepts a beat this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- ci  input  1  carry-in; ignored when sub=1
- sub  input  1  1 = A-B (B inverted, carry-in forced 1); 0 = A+B+ci
- out_valid  output  1  result beat valid
- out_ready  input  1  downstream accepts result
- sum  output  WIDTH  result, modulo 2^WIDTH
- co  output  1  carry out of MSB (for sub: 1 = no borrow)
- ovf  output  1  signed overflow = carry into MSB XOR carry out of MSB
- zero  output  1  sum == 0

Behaviour:
- Reset (reset_n=0, asynchronous): all stage valid bits 0 and all data registers 0. Hence out_valid=0, sum=0, co=0, ovf=0, zero=1 (zero is combinational from sum). in_ready is combinational and equals 1 during reset.
- Group k (bits k*GRP .. k*GRP+GRP-1):
  - g = a&b', p = a|b', where b' is b or ~b.
  - Intra-group carries c1..c(GRP) are computed in flattened sum-of-products lookahead form from group carry-in. Rippling is not allowed.
  - Stage k computes group k. Stage 0 takes carry-in = sub ? 1 : ci.
- Each stage register holds:
  - valid bit
  - completed low sum bits
  - remaining unprocessed a and b' bits (skewed forward)
  - group carry-out
  - the carry into bit WIDTH-1; the last stage only needs this bit
- Stall rule: stall = out_valid & ~out_ready.
  - When stall=0, every stage register loads from its predecessor. Stage 0 loads in_valid and the operands.
  - When stall=1, all stages hold.
  - in_ready = ~stall.
  - Transfer in occurs when in_valid & in_ready. Transfer out occurs when out_valid & out_ready.
- Latency: exactly N cycles from input transfer to out_valid, with no stall. Throughput is 1 beat/cycle.
- Bubbles (in_valid=0 while in_ready=1) propagate as valid=0 stages. They are not compressed.
- Outputs come directly from the last stage register; there is no combinational path from a/b to sum.
- Outputs are held stable while out_valid=1 and out_ready=0.
- in_valid must not affect a stalled pipeline. Operands presented during a stall are not captured; the source must hold them, per the handshake.
- Boundaries:
  - WIDTH=GRP gives a single-stage, 1-cycle latency block.
  - Carry chain wrap: a full WIDTH-bit propagate (e.g. all-ones + 1) must resolve correctly across all stages.
  - sub with b=0: co=1, sum=a.
  - Simultaneous out transfer and in transfer in the same cycle is legal and loses no beat.
- Reset mid-operation: all in-flight beats are discarded. There is no out_valid pulse afterwards. The first post-reset beat has latency N.
- sum, co and ovf are meaningful only when out_valid=1. With out_valid=0 they show the bubble contents (zeros after reset).

Test Plan:
- WIDTH=16, GRP=4, a=16'hFFFF, b=16'h0001, ci=0, sub=0 -> after 4 cycles: sum=16'h0000, co=1, ovf=0, zero=1.
- a=16'h7FFF, b=16'h0001, sub=0 -> sum=16'h8000, co=0, ovf=1; then a=16'h8000, b=16'h0001, sub=1 -> sum=16'h7FFF, co=1, ovf=1.
- Back-to-back stream of 8 beats (a=i*16'h1111, b=16'h0F0F, ci=i[0]), out_ready=1 -> 8 consecutive out_valid cycles starting at cycle 4, each matching the reference model.
- Same stream with out_ready low for cycles 6-8 -> in_ready=0 in those cycles, outputs frozen, no beat lost or duplicated, order preserved.
- Two beats in flight, reset_n pulsed low asynchronously mid-cycle -> out_valid=0 immediately and stays 0; next accepted beat appears exactly 4 cycles later.
- Randomised 10k beats at WIDTH=32/GRP=4 and WIDTH=8/GRP=8 with random valid/ready -> bit-exact match against a behavioural a±b model for sum, co, ovf and zero.

Source files
------------

// File: rtl/cla_pipe_adder.sv
// ---------------------------------------------------------------------------
// cla_pipe_adder
//
// Pipelined carry-lookahead adder/subtractor. The operands are cut into
// GRP-bit lookahead groups; pipeline stage k resolves group k with full
// intra-group lookahead and registers the partial sum, the group carry-out
// and the operand bits that later stages still need. Depth N = WIDTH/GRP.
// WIDTH must be a multiple of GRP and at least GRP.
//
// Ports
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   in_valid   operand beat valid
//   in_ready   block accepts a beat this cycle
//   a, b       operands (WIDTH bits)
//   ci         carry-in, ignored when sub=1
//   sub        1: a-b (b inverted, carry-in forced to 1); 0: a+b+ci
//   out_valid  result beat valid
//   out_ready  downstream accepts the result
//   sum        result modulo 2^WIDTH
//   co         carry out of the MSB (for sub: 1 = no borrow)
//   ovf        signed overflow (carry into MSB xor carry out of MSB)
//   zero       sum == 0
//
// Handshake: a beat moves across an interface on a rising edge where
// valid && ready. The only back-pressure point is the output: when
// out_valid && !out_ready the whole pipeline freezes and in_ready drops, so
// a source must hold its beat (and in_valid) until it sees in_ready. Empty
// slots (bubbles) travel through the pipe as valid=0 stages.
// ---------------------------------------------------------------------------
module cla_pipe_adder #(
  parameter int WIDTH = 32,
  parameter int GRP   = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             co,
  output logic             ovf,
  output logic             zero
);

  localparam int N = WIDTH / GRP;

  // Stage registers
  logic             r_valid [N];
  logic [WIDTH-1:0] r_sum   [N];
  logic [WIDTH-1:0] r_a     [N];
  logic [WIDTH-1:0] r_b     [N];
  logic             r_c     [N];
  logic             r_cmsb;

  // Inputs seen by each stage (stage 0 from the ports, others from k-1)
  logic             w_in_valid [N];
  logic [WIDTH-1:0] w_in_sum   [N];
  logic [WIDTH-1:0] w_in_a     [N];
  logic [WIDTH-1:0] w_in_b     [N];
  logic             w_in_c     [N];

  // Next values computed by each stage
  logic [WIDTH-1:0] w_nxt_sum [N];
  logic             w_nxt_c   [N];
  logic             w_cmsb;
  logic             w_stall;

  assign out_valid = r_valid[N-1];
  assign sum       = r_sum[N-1];
  assign co        = r_c[N-1];
  assign ovf       = r_cmsb ^ r_c[N-1];
  assign zero      = (sum == '0);
  assign w_stall   = out_valid & ~out_ready;
  assign in_ready  = ~w_stall;

  // Stage input selection. b is conditionally inverted once at entry, so
  // every later stage sees b' directly.
  always_comb begin
    w_in_valid[0] = in_valid;
    w_in_a[0]     = a;
    w_in_b[0]     = sub ? ~b : b;
    w_in_sum[0]   = '0;
    w_in_c[0]     = sub | ci;
    for (int k = 1; k < N; k++) begin
      w_in_valid[k] = r_valid[k-1];
      w_in_a[k]     = r_a[k-1];
      w_in_b[k]     = r_b[k-1];
      w_in_sum[k]   = r_sum[k-1];
      w_in_c[k]     = r_c[k-1];
    end
  end

  // Per-group lookahead. Every carry c[j] is a flat sum of products of the
  // group generate/propagate terms and the group carry-in c[0]; no carry is
  // built from another intra-group carry.
  always_comb begin
    logic [GRP-1:0] ga;
    logic [GRP-1:0] gb;
    logic [GRP-1:0] g;
    logic [GRP-1:0] p;
    logic [GRP-1:0] s;
    logic [GRP:0]   c;
    logic           t;
    logic           acc;
    ga     = '0;
    gb     = '0;
    g      = '0;
    p      = '0;
    s      = '0;
    c      = '0;
    t      = 1'b0;
    acc    = 1'b0;
    w_cmsb = 1'b0;
    for (int k = 0; k < N; k++) begin
      ga   = w_in_a[k][k*GRP +: GRP];
      gb   = w_in_b[k][k*GRP +: GRP];
      g    = ga & gb;
      p    = ga | gb;
      c    = '0;
      c[0] = w_in_c[k];
      for (int j = 1; j <= GRP; j++) begin
        // carry-in term: c0 & p[0] & ... & p[j-1]
        t = w_in_c[k];
        for (int m = 0; m < j; m++) t = t & p[m];
        acc = t;
        // generate terms: g[i] & p[i+1] & ... & p[j-1]
        for (int i = 0; i < j; i++) begin
          t = g[i];
          for (int m = i + 1; m < j; m++) t = t & p[m];
          acc = acc | t;
        end
        c[j] = acc;
      end
      s = ga ^ gb ^ c[GRP-1:0];
      w_nxt_sum[k]                = w_in_sum[k];
      w_nxt_sum[k][k*GRP +: GRP]  = s;
      w_nxt_c[k]                  = c[GRP];
      // Bit WIDTH-1 lives in the last group; its carry-in feeds ovf.
      if (k == N - 1) w_cmsb = c[GRP-1];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < N; k++) begin
        r_valid[k] <= 1'b0;
        r_sum[k]   <= '0;
        r_a[k]     <= '0;
        r_b[k]     <= '0;
        r_c[k]     <= 1'b0;
      end
      r_cmsb <= 1'b0;
    end else if (!w_stall) begin
      for (int k = 0; k < N; k++) begin
        r_valid[k] <= w_in_valid[k];
        r_sum[k]   <= w_nxt_sum[k];
        r_a[k]     <= w_in_a[k];
        r_b[k]     <= w_in_b[k];
        r_c[k]     <= w_nxt_c[k];
      end
      r_cmsb <= w_cmsb;
    end
  end

endmodule
